// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the stream_mux_rr N:1 streaming multiplexer.
// Optional packet locking is enabled with STREAM_MUX_LAST_EN.
package stream_mux_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WIDTH  = 8;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;

  // Widest grant vector the index helper accepts; callers zero-extend into it.
  localparam int MAX_CH     = 64;

  function automatic int oh2idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the stream_mux_rr block and one consumer.
// STREAM_MUX_LAST_EN adds per-channel in_last and a registered out_last.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
`ifdef STREAM_MUX_LAST_EN
  logic [NUM_CH-1:0]       in_last;
  logic                    out_last;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_sel, out_last);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_sel, out_last);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin search from ptr_i, or fixed
// priority (lowest index) when rr_en_i is low.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  input  logic              rr_en_i,
  output logic [NUM_CH-1:0] grant_o
);

  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    int               start;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    start   = rr_en_i ? int'(ptr_i) : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = SEL_W'((start + k) % NUM_CH);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with round-robin or fixed-priority arbitration and
// a single registered output stage. STREAM_MUX_LAST_EN enables packet locking.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RR_MODE = ARB_RR,
  parameter int SEL_W   = $clog2(NUM_CH)
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_rr_if.slave bus
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;
  logic [NUM_CH-1:0] req, grant;
  logic [WIDTH-1:0]  win_data;
  logic [SEL_W-1:0]  win_idx;
  logic              load_ok, xfer, word_end;

`ifdef STREAM_MUX_LAST_EN
  logic              lock_q,     lock_d;
  logic [SEL_W-1:0]  lock_ch_q,  lock_ch_d;
  logic              out_last_q, out_last_d;

  // While a packet is open only its own channel may request.
  assign req      = lock_q ? (bus.in_valid & (NUM_CH'(1) << lock_ch_q)) : bus.in_valid;
  assign word_end = |(grant & bus.in_last);
  assign bus.out_last = out_last_q;
`else
  assign req      = bus.in_valid;
  assign word_end = 1'b1;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .rr_en_i (RR_MODE == ARB_RR),
    .grant_o (grant)
  );

  assign load_ok      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = grant & {NUM_CH{load_ok & rst_n}};
  assign xfer         = |bus.in_ready;
  assign win_idx      = SEL_W'(oh2idx(MAX_CH'(grant)));

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win_data = win_data | bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_LAST_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_sel_d   = win_idx;
      // The pointer moves past a channel only once its packet has ended.
      if (word_end) ptr_d = (win_idx == SEL_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
`ifdef STREAM_MUX_LAST_EN
      out_last_d  = word_end;
      lock_d      = ~word_end;
      lock_ch_d   = win_idx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_LAST_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin instance checked through a
// scoreboard, plus a fixed-priority instance checked every cycle.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops   = 0;
  exp_t sb[$];

  stream_mux_rr_if #(.NUM_CH(N), .WIDTH(W)) bus_a ();
  stream_mux_rr_if #(.NUM_CH(N), .WIDTH(W)) bus_b ();

  stream_mux_rr #(.NUM_CH(N), .WIDTH(W), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  stream_mux_rr #(.NUM_CH(N), .WIDTH(W), .RR_MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [1:0] s, input logic l);
    exp_t e;
    e.data = d; e.sel = s; e.last = l;
    sb.push_back(e);
    pushes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      check("sb_level", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        check("sb_data", bus_a.out_data, e.data);
        check("sb_sel",  bus_a.out_sel,  e.sel);
`ifdef STREAM_MUX_LAST_EN
        check("sb_last", bus_a.out_last, e.last);
`endif
      end
    end
  end

  // Fixed priority with channels 1 and 3 valid: channel 1 always wins.
  always @(negedge clk) begin
    if (rst_n) begin
      check("fix_in_ready", bus_b.in_ready, 4'b0010);
      if (bus_b.out_valid) begin
        check("fix_sel",  bus_b.out_sel,  2'd1);
        check("fix_data", bus_b.out_data, 8'h21);
      end
    end
  end

  initial begin
    bus_a.in_valid  = 4'b1111;
    bus_a.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 4'b1010;
    bus_b.in_data   = {8'h23, 8'h22, 8'h21, 8'h20};
    bus_b.out_ready = 1'b1;
`ifdef STREAM_MUX_LAST_EN
    bus_a.in_last   = 4'b1111;
    bus_b.in_last   = 4'b1111;
`endif
    rst_n = 1'b0;

    // Reset state, with requests present
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus_a.out_valid, 1'b0);
    check("rst_out_data",  bus_a.out_data,  8'h00);
    check("rst_out_sel",   bus_a.out_sel,   2'd0);
    check("rst_in_ready",  bus_a.in_ready,  4'b0000);

    // Round-robin fairness: 10,11,12,13,10 back-to-back
    step();
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_in_ready", bus_a.in_ready, 4'b0001 << (k % 4));
      if (k > 0) check("rr_no_bubble", bus_a.out_valid, 1'b1);
      push(8'h10 + 8'(k % 4), 2'(k % 4), 1'b1);
      step();
    end
    bus_a.out_ready = 1'b0;

    // Backpressure: word held, no input accepted
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_valid",    bus_a.out_valid, 1'b1);
      check("bp_data",     bus_a.out_data,  8'h10);
      check("bp_sel",      bus_a.out_sel,   2'd0);
      check("bp_in_ready", bus_a.in_ready,  4'b0000);
    end
    step();
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus_a.in_ready, 4'b0010);
    push(8'h11, 2'd1, 1'b1);
    step();
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    check("bp_next_valid", bus_a.out_valid, 1'b1);
    step();
    @(negedge clk);
    check("drain_valid", bus_a.out_valid, 1'b0);

    // Single channel
    step();
    bus_a.in_valid = 4'b0100;
    bus_a.in_data[2*W +: W] = 8'hA5;
    @(negedge clk);
    check("single_in_ready", bus_a.in_ready, 4'b0100);
    push(8'hA5, 2'd2, 1'b1);
    step();
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    check("single_valid", bus_a.out_valid, 1'b1);
    check("single_data",  bus_a.out_data,  8'hA5);
    check("single_sel",   bus_a.out_sel,   2'd2);
    step();
    @(negedge clk);
    check("single_drain", bus_a.out_valid, 1'b0);

    // Reset mid-stream while a word is held
    step();
    bus_a.in_data[1*W +: W] = 8'h77;
    bus_a.in_valid  = 4'b0010;
    bus_a.out_ready = 1'b0;
    step();
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    check("mid_valid", bus_a.out_valid, 1'b1);
    check("mid_sel",   bus_a.out_sel,   2'd1);
    #1;
    rst_n = 1'b0;
    bus_a.in_valid = 4'b1111;
    #1;
    check("async_valid",    bus_a.out_valid, 1'b0);
    check("async_data",     bus_a.out_data,  8'h00);
    check("async_sel",      bus_a.out_sel,   2'd0);
    check("async_in_ready", bus_a.in_ready,  4'b0000);
    bus_a.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_grant", bus_a.in_ready, 4'b0001);
    push(8'h10, 2'd0, 1'b1);
    step();
    bus_a.in_valid = 4'b0000;

`ifdef STREAM_MUX_LAST_EN
    // Packet lock: ch0 three words, ch1 waits for ch0's last word
    step();
    bus_a.in_valid = 4'b0001;
    bus_a.in_data[0 +: W] = 8'hA0;
    bus_a.in_last = 4'b1110;
    @(negedge clk);
    check("lk_ready0", bus_a.in_ready, 4'b0001);
    push(8'hA0, 2'd0, 1'b0);
    step();
    bus_a.in_valid = 4'b0011;
    bus_a.in_data[0 +: W] = 8'hA1;
    bus_a.in_data[W +: W] = 8'hB1;
    @(negedge clk);
    check("lk_ready1", bus_a.in_ready, 4'b0001);
    push(8'hA1, 2'd0, 1'b0);
    step();
    bus_a.in_data[0 +: W] = 8'hA2;
    bus_a.in_last = 4'b1111;
    @(negedge clk);
    check("lk_ready2", bus_a.in_ready, 4'b0001);
    push(8'hA2, 2'd0, 1'b1);
    step();
    bus_a.in_valid = 4'b0010;
    @(negedge clk);
    check("lk_ready3", bus_a.in_ready, 4'b0010);
    push(8'hB1, 2'd1, 1'b1);
    step();
    bus_a.in_valid = 4'b0000;
`endif

    step();
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("pop_count",  32'(pops), 32'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 streaming multiplexer with valid/ready handshakes on every input channel and on the output.
- Selects between channels by round-robin or fixed-priority arbitration, and registers the winning word in a single output stage.
- Generalises the combinational 2:1 select into a channel-count/width-scalable block with flow control and fairness.
- Sits between multiple producers (e.g. per-lane sample sources) and one shared consumer.

Parameters:
- NUM_CH, 4, number of input channels; must be >= 2.
- WIDTH, 8, data width per channel in bits.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins).
- SEL_W, $clog2(NUM_CH), derived width of the channel index; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel ready; one-hot or zero.
- out_valid  output  1  output word held.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts.

Behaviour:
- Reset (asynchronous, active-low): out_valid=0, out_data=0, out_sel=0, rr pointer=0. in_ready is all-zero while rst_n=0.
- Definitions:
  - load_ok = ~out_valid | out_ready.
  - grant = one-hot combinational arbitration over in_valid.
  - in_ready = grant & {NUM_CH{load_ok}}.
- Input transfer on channel i: in_valid[i] & in_ready[i]. At most one channel transfers per cycle.
- On a transfer, the next edge sets out_data=in_data[i], out_sel=i, out_valid=1. Latency from input acceptance to out_valid is 1 cycle.
- Output transfer: out_valid & out_ready. If no input transfer occurs in the same cycle, out_valid goes to 0 at the next edge.
- Simultaneous output and input transfer: the register reloads with no bubble. Sustained throughput is 1 word/cycle.
- out_valid=1 & out_ready=0: out_data and out_sel hold stable and in_ready=0. Inputs are not consumed; producers must hold valid/data.
- Round-robin (RR_MODE=1):
  - Search starts at the pointer and wraps modulo NUM_CH.
  - After granting channel i, pointer = (i+1) mod NUM_CH; at i=NUM_CH-1 it wraps to 0.
  - The pointer is unchanged when there is no transfer.
- Fixed priority (RR_MODE=0): lowest-indexed valid channel wins; the pointer is unused.
- No in_valid asserted: grant=0, no load, and out_valid follows the output-transfer rule.
- Reset asserted mid-operation: the held word is discarded with no output transfer, and arbitration restarts at channel 0.
- A producer dropping in_valid without a transfer is tolerated; grant is recomputed every cycle.

Optional Feature:
- Macro: STREAM_MUX_LAST_EN.
- Defined:
  - Adds ports in_last (input, NUM_CH) and out_last (output, 1, reset 0).
  - out_last is registered alongside out_data.
  - After a transfer with in_last[i]=0, the arbiter locks to channel i. Other channels get no grant until channel i's transfer with in_last[i]=1 completes.
  - The rr pointer advances only on the last word.
  - Reset clears the lock.
- Undefined: no last ports; every word re-arbitrates independently.

Decomposition:
- Package stream_mux_pkg holds:
  - a helper function for the one-hot to index conversion;
  - default constants for NUM_CH and WIDTH;
  - the RR_MODE encodings as localparams (ARB_FIXED=0, ARB_RR=1).
- One sub-module, rr_arbiter, takes req[NUM_CH], ptr and a mode select, and returns a one-hot grant. It is combinational and reusable.
- The pointer, lock and output register live in stream_mux_rr.

Test Plan (NUM_CH=4, WIDTH=8):
1. Reset mid-stream: drive rst_n=0 while out_valid=1 -> out_valid, out_data and out_sel are 0 immediately (asynchronous). After release, the first grant goes to channel 0.
2. Single channel: in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> one cycle later out_valid=1, out_data=8'hA5, out_sel=2, and in_ready was 4'b0100.
3. Round-robin fairness: all in_valid=1 with data ch_i=8'h10+i, out_ready=1 -> out_data sequence 10,11,12,13,10 on consecutive cycles with no bubbles.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0. Release -> next word follows back-to-back.
5. Fixed priority (RR_MODE=0): in_valid=4'b1010 held -> channel 1 is granted every cycle and channel 3 is starved.
6. With STREAM_MUX_LAST_EN: ch0 sends 3 words (last on the third) while ch1 is valid -> the ch1 word appears only after ch0's last word, and out_last=1 on that third word.
